v7_filter_ctrl: RTL and testbench
=================================

// Module: v7_filter_ctrl
// PURPOSE
//  Event sequencer for the v7 trapezoidal filter. It arms on a threshold crossing of
//  the filter output and waits out the rise time. It then captures the flat-top peak
//  over a window and hands {amplitude, timestamp, flags} downstream on a valid/ready port.
//  Finally it pulses the filter's active-low reset to flush the accumulators before re-arming.
// PARAMETERS
//  SIZE_FILTER_DATA  16  width of filter output / event amplitude (signed in, unsigned out)
//  PEAK_DELAY        12  cycles in RISE after trigger before peak sampling (>=1)
//  PEAK_WIN           4  cycles of peak sampling (max-hold) (>=1)
//  FLUSH_CYCLES      18  cycles filt_reset held low after an event/abort (>=1; >= l+k+2 of filter)
//  TS_WIDTH          32  timestamp counter width
//  CNT_WIDTH         16  width of drop/glitch counters
// PORTS
//  clk            in   1                 system clock, all logic on rising edge
//  reset          in   1                 asynchronous, active-low reset
//  enable         in   1                 1 = run; 0 = hold filter cleared
//  cfg_threshold  in   SIZE_FILTER_DATA  trigger level (signed), sampled every cycle
//  filter_data    in   SIZE_FILTER_DATA  filter output_data (signed)
//  filt_reset     out  1                 active-low reset to the filter (0 = clear)
//  ev_valid       out  1                 event word valid
//  ev_ready       in   1                 downstream accepts when ev_valid&ev_ready
//  ev_amp         out  SIZE_FILTER_DATA  peak (max) amplitude over the window
//  ev_time        out  TS_WIDTH          timestamp of trigger edge
//  ev_sat         out  1                 peak == 2**(SIZE_FILTER_DATA-1)-1 (filter clipped)
//  drop_cnt       out  CNT_WIDTH         events lost, output register full (saturating)
//  glitch_cnt     out  CNT_WIDTH         triggers aborted in RISE (saturating)
//  busy           out  1                 state != IDLE && state != ARMED
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; filt_reset=0; ev_valid=0; ev_amp/ev_time/ev_sat=0;
//   drop_cnt=glitch_cnt=0; ts=0; busy=0. Release is synchronous to the next edge.
//  ts: free-running TS_WIDTH counter, +1 every cycle, wraps 2**TS_WIDTH-1 -> 0.
//  filt_reset is registered: 0 in IDLE and FLUSH, 1 otherwise.
//  FSM (one transition per edge, all compares signed):
//   IDLE  : enable=1 -> ARMED.
//   ARMED : filter_data > cfg_threshold -> RISE; latch trig_ts=ts; cnt=PEAK_DELAY-1.
//           Equality does not trigger.
//   RISE  : filter_data <= cfg_threshold -> ARMED, glitch_cnt+1 (saturating).
//           Otherwise cnt==0 -> PEAK, cnt=PEAK_WIN-1, max=filter_data; else cnt-1.
//   PEAK  : max=max(max,filter_data) every cycle (window = PEAK_WIN samples incl. entry sample).
//           cnt==0 -> EMIT; else cnt-1. No threshold abort in PEAK.
//   EMIT  : one cycle; if ev_valid==0 or ev_ready==1 this cycle, load ev_amp=max
//           (negative clamps to 0), ev_time=trig_ts, ev_sat, ev_valid=1.
//           Else drop, drop_cnt+1 (saturating). -> FLUSH, cnt=FLUSH_CYCLES-1.
//   FLUSH : cnt==0 -> (enable ? ARMED : IDLE); else cnt-1.
//  Latency: trigger edge to ev_valid=1 = PEAK_DELAY+PEAK_WIN+1 cycles.
//  enable=0 in ARMED/RISE/PEAK -> FLUSH, no event, no counter change.
//   In EMIT the event still completes. In FLUSH, FLUSH completes and then goes to IDLE.
//  Handshake: ev_valid clears on an edge with ev_ready=1 unless reloaded the same edge.
//   ev_* are stable while ev_valid=1 and ev_ready=0. ev_ready is ignored when ev_valid=0.
//  Counters stick at 2**CNT_WIDTH-1. Only reset clears them.
//  Mid-operation reset: immediate return to reset values. Any in-flight event is lost, not counted.
// TESTING
//  1 reset=0 then 1, enable=0 -> filt_reset=0, ev_valid=0, state IDLE for 20 cycles
//  2 enable=1, thr=100; step 0->500 held 40 cyc, ev_ready=1
//    -> ev_valid after 12+4+1 cyc, ev_amp=500, ev_time=ts at crossing, ev_sat=0
//    -> filt_reset low 18 cyc, then re-arm
//  3 thr=100; pulse 150 for 5 cyc then 0 -> glitch_cnt=1, no ev_valid, back to ARMED, filt_reset stays 1
//  4 ev_ready=0; two valid pulses (amps 300, 700) -> first held stable (300), drop_cnt=1;
//    ev_ready=1 one cycle -> ev_valid=0
//  5 PEAK samples 400,32767,500,450 -> ev_amp=32767, ev_sat=1;
//    data == thr exactly -> no trigger
//  6 enable=0 during PEAK -> FLUSH 18 cyc then IDLE, no event;
//    async reset mid-RISE -> all outputs at reset values same cycle

Source files
------------

// File: rtl/v7_filter_ctrl.sv
// -----------------------------------------------------------------------------
// v7_filter_ctrl
//   Event sequencer for the v7 trapezoidal filter. Arms on a signed threshold
//   crossing of the filter output, waits out the rise time, max-holds the
//   flat-top over a short window and hands {amplitude, timestamp, flags}
//   downstream on a valid/ready port. After every event (or abort) the filter
//   is held in reset for a fixed number of cycles to flush its accumulators.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   enable         in   1 = run, 0 = hold filter cleared
//   cfg_threshold  in   signed trigger level, sampled every cycle
//   filter_data    in   signed filter output
//   filt_reset     out  active-low reset to the filter (0 = clear)
//   ev_valid       out  event word valid
//   ev_ready       in   downstream accepts when ev_valid & ev_ready
//   ev_amp         out  peak amplitude over the window (negative clamps to 0)
//   ev_time        out  timestamp of the trigger edge
//   ev_sat         out  peak equals the largest positive filter value
//   drop_cnt       out  events lost because the output register was full
//   glitch_cnt     out  triggers aborted during the rise time
//   busy           out  sequencer is neither idle nor armed
// -----------------------------------------------------------------------------
module v7_filter_ctrl #(
   parameter int unsigned SIZE_FILTER_DATA = 16,
   parameter int unsigned PEAK_DELAY       = 12,
   parameter int unsigned PEAK_WIN         = 4,
   parameter int unsigned FLUSH_CYCLES     = 18,
   parameter int unsigned TS_WIDTH         = 32,
   parameter int unsigned CNT_WIDTH        = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [SIZE_FILTER_DATA-1:0] cfg_threshold,
   input  logic [SIZE_FILTER_DATA-1:0] filter_data,
   output logic                        filt_reset,
   output logic                        ev_valid,
   input  logic                        ev_ready,
   output logic [SIZE_FILTER_DATA-1:0] ev_amp,
   output logic [TS_WIDTH-1:0]         ev_time,
   output logic                        ev_sat,
   output logic [CNT_WIDTH-1:0]        drop_cnt,
   output logic [CNT_WIDTH-1:0]        glitch_cnt,
   output logic                        busy
);

   // One shared phase counter serves rise delay, peak window and flush.
   localparam int unsigned CNT_MAX =
      (PEAK_DELAY > PEAK_WIN)
         ? ((PEAK_DELAY > FLUSH_CYCLES) ? PEAK_DELAY : FLUSH_CYCLES)
         : ((PEAK_WIN   > FLUSH_CYCLES) ? PEAK_WIN   : FLUSH_CYCLES);
   localparam int unsigned PH_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [PH_W-1:0] C_DELAY = PH_W'(PEAK_DELAY - 1);
   localparam logic [PH_W-1:0] C_WIN   = PH_W'(PEAK_WIN - 1);
   localparam logic [PH_W-1:0] C_FLUSH = PH_W'(FLUSH_CYCLES - 1);

   // Largest positive value the filter can produce; a peak here means clipping.
   localparam logic [SIZE_FILTER_DATA-1:0] C_SAT = {1'b0, {(SIZE_FILTER_DATA-1){1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_RISE,
      S_PEAK,
      S_EMIT,
      S_FLUSH
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [PH_W-1:0]             r_cnt;
   logic [PH_W-1:0]             w_cnt_nxt;
   logic [SIZE_FILTER_DATA-1:0] r_max;
   logic [SIZE_FILTER_DATA-1:0] w_max_nxt;
   logic [TS_WIDTH-1:0]         r_ts;
   logic [TS_WIDTH-1:0]         r_trig_ts;
   logic                        w_trig_ld;
   logic                        w_glitch;
   logic                        w_emit;
   logic                        w_above;
   logic                        w_new_max;
   logic                        w_slot_free;

   logic                        r_filt_reset;
   logic                        r_ev_valid;
   logic [SIZE_FILTER_DATA-1:0] r_ev_amp;
   logic [TS_WIDTH-1:0]         r_ev_time;
   logic                        r_ev_sat;
   logic [CNT_WIDTH-1:0]        r_drop_cnt;
   logic [CNT_WIDTH-1:0]        r_glitch_cnt;

   assign w_above     = $signed(filter_data) > $signed(cfg_threshold);
   assign w_new_max   = $signed(filter_data) > $signed(r_max);
   assign w_slot_free = !r_ev_valid || ev_ready;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------- next state / control
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_max_nxt   = r_max;
      w_trig_ld   = 1'b0;
      w_glitch    = 1'b0;
      w_emit      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            // Disable wins over a simultaneous trigger: no event, no count.
            if (!enable) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = C_FLUSH;
            end else if (w_above) begin
               w_state_nxt = S_RISE;
               w_cnt_nxt   = C_DELAY;
               w_trig_ld   = 1'b1;
            end
         end
         S_RISE: begin
            if (!enable) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = C_FLUSH;
            end else if (!w_above) begin
               w_state_nxt = S_ARMED;
               w_glitch    = 1'b1;
            end else if (r_cnt == '0) begin
               // Last rise sample opens the peak window.
               w_state_nxt = S_PEAK;
               w_cnt_nxt   = C_WIN;
               w_max_nxt   = filter_data;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_PEAK: begin
            if (!enable) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = C_FLUSH;
            end else if (r_cnt == '0) begin
               // Window already holds PEAK_WIN samples including the entry one,
               // so the closing cycle does not fold in another sample.
               w_state_nxt = S_EMIT;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
               if (w_new_max) begin
                  w_max_nxt = filter_data;
               end
            end
         end
         S_EMIT: begin
            w_emit      = 1'b1;
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = C_FLUSH;
         end
         S_FLUSH: begin
            if (r_cnt == '0) begin
               w_state_nxt = enable ? S_ARMED : S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt        <= '0;
         r_max        <= '0;
         r_ts         <= '0;
         r_trig_ts    <= '0;
         r_filt_reset <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_max <= w_max_nxt;
         r_ts  <= r_ts + 1'b1;
         if (w_trig_ld) begin
            r_trig_ts <= r_ts;
         end
         // Registered from the next state so the filter reset tracks the
         // IDLE/FLUSH residency exactly, without a cycle of lag.
         r_filt_reset <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FLUSH);
      end
   end

   // -------------------------------------------------- output event register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ev_valid <= 1'b0;
         r_ev_amp   <= '0;
         r_ev_time  <= '0;
         r_ev_sat   <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_emit && w_slot_free) begin
            r_ev_valid <= 1'b1;
            r_ev_amp   <= r_max[SIZE_FILTER_DATA-1] ? '0 : r_max;
            r_ev_time  <= r_trig_ts;
            r_ev_sat   <= (r_max == C_SAT);
         end else if (r_ev_valid && ev_ready) begin
            r_ev_valid <= 1'b0;
         end
         if (w_emit && !w_slot_free && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_glitch_cnt <= '0;
      end else if (w_glitch && (r_glitch_cnt != '1)) begin
         r_glitch_cnt <= r_glitch_cnt + 1'b1;
      end
   end

   assign filt_reset = r_filt_reset;
   assign ev_valid   = r_ev_valid;
   assign ev_amp     = r_ev_amp;
   assign ev_time    = r_ev_time;
   assign ev_sat     = r_ev_sat;
   assign drop_cnt   = r_drop_cnt;
   assign glitch_cnt = r_glitch_cnt;
   assign busy       = (r_state != S_IDLE) && (r_state != S_ARMED);

endmodule

// File: tb/tb_v7_filter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_v7_filter_ctrl
//   Directed and randomized stimulus for v7_filter_ctrl, checked every cycle
//   against an event-level reference model that scans the stimulus arrays for
//   trigger / rise / window / flush spans and then replays the output
//   register and saturating counters.
// -----------------------------------------------------------------------------
module tb_v7_filter_ctrl;

   localparam int DW   = 16;
   localparam int TW   = 32;
   localparam int CW   = 4;
   localparam int D    = 12;
   localparam int W    = 4;
   localparam int F    = 18;
   localparam int CMAX = (1 << CW) - 1;
   localparam int NMAX = 1200;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          ev_ready = 1'b0;
   logic [DW-1:0] cfg_threshold = '0;
   logic [DW-1:0] filter_data = '0;
   logic          filt_reset;
   logic          ev_valid;
   logic [DW-1:0] ev_amp;
   logic [TW-1:0] ev_time;
   logic          ev_sat;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] glitch_cnt;
   logic          busy;

   v7_filter_ctrl #(
      .SIZE_FILTER_DATA (DW),
      .PEAK_DELAY       (D),
      .PEAK_WIN         (W),
      .FLUSH_CYCLES     (F),
      .TS_WIDTH         (TW),
      .CNT_WIDTH        (CW)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .cfg_threshold (cfg_threshold),
      .filter_data   (filter_data),
      .filt_reset    (filt_reset),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_amp        (ev_amp),
      .ev_time       (ev_time),
      .ev_sat        (ev_sat),
      .drop_cnt      (drop_cnt),
      .glitch_cnt    (glitch_cnt),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus, indexed by the edge that samples it
   int n_len;
   int s_data [NMAX];
   int s_thr  [NMAX];
   bit s_en   [NMAX];
   bit s_rdy  [NMAX];

   // model results, value expected just after each edge
   bit x_fr    [NMAX];
   bit x_busy  [NMAX];
   bit x_valid [NMAX];
   int x_amp   [NMAX];
   int x_time  [NMAX];
   bit x_sat   [NMAX];
   int x_drop  [NMAX];
   int x_glit  [NMAX];
   bit emit_at [NMAX];
   int emit_mx [NMAX];
   int emit_ts [NMAX];
   bit g_inc   [NMAX];

   // observed DUT values, for spot checks after a run
   int o_valid [NMAX];
   int o_amp   [NMAX];
   int o_time  [NMAX];
   int o_sat   [NMAX];
   int o_fr    [NMAX];
   int o_busy  [NMAX];
   int o_drop  [NMAX];
   int o_glit  [NMAX];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------ reference
   task automatic mark(input int k, input bit fr, input bit bz);
      if (k < n_len) begin
         x_fr[k]   = fr;
         x_busy[k] = bz;
      end
   endtask

   // Filter held cleared for F cycles starting at edge f; the edge after that
   // lands in ARMED or IDLE depending on enable.
   task automatic flush_model(input int f, output int e_out, output bit armed_out);
      int k;
      for (int i = 0; i < F; i++) mark(f + i, 1'b0, 1'b1);
      k = f + F;
      armed_out = 1'b0;
      if (k < n_len) begin
         armed_out = s_en[k];
         mark(k, s_en[k], 1'b0);
      end
      e_out = k + 1;
   endtask

   task automatic build_model();
      int  e, t, k, mx, v_amp, v_time, drp, gl;
      bit  armed, ended, v, v_sat;
      for (int i = 0; i < NMAX; i++) begin
         x_fr[i] = 0; x_busy[i] = 0; emit_at[i] = 0; emit_mx[i] = 0; emit_ts[i] = 0; g_inc[i] = 0;
      end
      e = 0;
      armed = 1'b0;
      while (e < n_len) begin
         if (!armed) begin
            armed = s_en[e];
            mark(e, armed, 1'b0);
            e++;
         end else if (!s_en[e]) begin
            flush_model(e, e, armed);
         end else if (s_data[e] <= s_thr[e]) begin
            mark(e, 1'b1, 1'b0);
            e++;
         end else begin
            // trigger at edge t: resolve the whole event by looking ahead
            t = e;
            mark(t, 1'b1, 1'b1);
            ended = 1'b0;
            for (int j = 1; j <= D + W + 1 && !ended; j++) begin
               k = t + j;
               if (k >= n_len) begin
                  e = n_len;
                  ended = 1'b1;
               end else if (j <= D + W && !s_en[k]) begin
                  flush_model(k, e, armed);
                  ended = 1'b1;
               end else if (j <= D && s_data[k] <= s_thr[k]) begin
                  g_inc[k] = 1'b1;
                  mark(k, 1'b1, 1'b0);
                  e = k + 1;
                  ended = 1'b1;
               end else if (j == D + W + 1) begin
                  mx = s_data[t + D];
                  for (int i = 1; i < W; i++)
                     if (s_data[t + D + i] > mx) mx = s_data[t + D + i];
                  emit_at[k] = 1'b1;
                  emit_mx[k] = mx;
                  emit_ts[k] = t;
                  flush_model(k, e, armed);
                  ended = 1'b1;
               end else begin
                  mark(k, 1'b1, 1'b1);
               end
            end
         end
      end
      // output register and counters
      v = 0; v_amp = 0; v_time = 0; v_sat = 0; drp = 0; gl = 0;
      for (int i = 0; i < n_len; i++) begin
         if (emit_at[i]) begin
            if (!v || s_rdy[i]) begin
               v      = 1'b1;
               v_amp  = (emit_mx[i] < 0) ? 0 : emit_mx[i];
               v_time = emit_ts[i];
               v_sat  = (emit_mx[i] == 32767);
            end else if (drp < CMAX) begin
               drp++;
            end
         end else if (v && s_rdy[i]) begin
            v = 1'b0;
         end
         if (g_inc[i] && gl < CMAX) gl++;
         x_valid[i] = v; x_amp[i] = v_amp; x_time[i] = v_time; x_sat[i] = v_sat;
         x_drop[i] = drp; x_glit[i] = gl;
      end
   endtask

   // ------------------------------------------------------------ stimulus
   task automatic clear_stim(input int len, input int thr, input bit en, input bit rdy);
      n_len = len;
      for (int i = 0; i < NMAX; i++) begin
         s_data[i] = 0; s_thr[i] = thr; s_en[i] = en; s_rdy[i] = rdy;
      end
   endtask

   task automatic set_data(input int a, input int b, input int val);
      for (int i = a; i <= b; i++) s_data[i] = val;
   endtask

   task automatic gen_random(input int len, input int rdy_pct, input int maxdur);
      int i, lvl, dur, thr, en_left;
      bit en_now;
      n_len   = len;
      thr     = int'($urandom_range(400, 0)) - 150;
      en_now  = 1'b1;
      en_left = int'($urandom_range(300, 30));
      i = 0;
      while (i < len) begin
         if ($urandom_range(9, 0) == 0) thr = int'($urandom_range(400, 0)) - 150;
         case ($urandom_range(9, 0))
            0, 1, 2, 3: lvl = thr - int'($urandom_range(200, 1));
            4:          lvl = thr;
            5, 6, 7:    lvl = thr + int'($urandom_range(800, 1));
            8:          lvl = 32767;
            default:    lvl = -int'($urandom_range(32768, 0));
         endcase
         dur = int'($urandom_range(maxdur, 1));
         for (int j = 0; j < dur && i < len; j++) begin
            s_data[i] = lvl;
            s_thr[i]  = thr;
            s_en[i]   = en_now;
            s_rdy[i]  = (int'($urandom_range(99, 0)) < rdy_pct);
            en_left--;
            if (en_left <= 0) begin
               en_now  = !en_now;
               en_left = en_now ? int'($urandom_range(300, 30)) : int'($urandom_range(40, 1));
            end
            i++;
         end
      end
   endtask

   // ------------------------------------------------------------ run engine
   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, ".fr"},    filt_reset, 0);
      check_eq({pfx, ".valid"}, ev_valid,   0);
      check_eq({pfx, ".amp"},   ev_amp,     0);
      check_eq({pfx, ".time"},  ev_time,    0);
      check_eq({pfx, ".sat"},   ev_sat,     0);
      check_eq({pfx, ".drop"},  drop_cnt,   0);
      check_eq({pfx, ".glit"},  glitch_cnt, 0);
      check_eq({pfx, ".busy"},  busy,       0);
   endtask

   task automatic apply_reset();
      reset = 1'b0; enable = 1'b0; ev_ready = 1'b0; filter_data = '0; cfg_threshold = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_case(input int id);
      string p;
      build_model();
      apply_reset();
      for (int n = 0; n <= n_len; n++) begin
         if (n == 0) begin
            check_reset_vals($sformatf("r%0d.rst", id));
         end else begin
            p = $sformatf("r%0d.e%0d", id, n - 1);
            o_valid[n-1] = int'(ev_valid); o_amp[n-1] = int'(ev_amp); o_time[n-1] = int'(ev_time);
            o_sat[n-1] = int'(ev_sat); o_fr[n-1] = int'(filt_reset); o_busy[n-1] = int'(busy);
            o_drop[n-1] = int'(drop_cnt); o_glit[n-1] = int'(glitch_cnt);
            check_eq({p, ".fr"},    filt_reset, 64'(x_fr[n-1]));
            check_eq({p, ".busy"},  busy,       64'(x_busy[n-1]));
            check_eq({p, ".valid"}, ev_valid,   64'(x_valid[n-1]));
            check_eq({p, ".amp"},   ev_amp,     64'(x_amp[n-1]));
            check_eq({p, ".time"},  ev_time,    64'(x_time[n-1]));
            check_eq({p, ".sat"},   ev_sat,     64'(x_sat[n-1]));
            check_eq({p, ".drop"},  drop_cnt,   64'(x_drop[n-1]));
            check_eq({p, ".glit"},  glitch_cnt, 64'(x_glit[n-1]));
         end
         if (n < n_len) begin
            enable        = s_en[n];
            ev_ready      = s_rdy[n];
            filter_data   = DW'(s_data[n]);
            cfg_threshold = DW'(s_thr[n]);
            @(negedge clk);
         end
      end
   endtask

   int prof_len [6] = '{600, 600, 1100, 600, 600, 600};
   int prof_rdy [6] = '{70, 30, 2, 90, 50, 100};
   int prof_dur [6] = '{30, 8, 40, 20, 12, 25};

   initial begin
      // idle with enable low: filter held cleared, nothing happens
      clear_stim(20, 0, 1'b0, 1'b0);
      run_case(0);
      check_eq("idle.fr19",   o_fr[19],   0);
      check_eq("idle.busy19", o_busy[19], 0);

      // step event, short glitch, clipped peak, equality never triggers
      clear_stim(140, 100, 1'b1, 1'b1);
      set_data(5, 39, 500);
      set_data(50, 54, 150);
      set_data(70, 81, 200);
      s_data[82] = 400; s_data[83] = 32767; s_data[84] = 500; s_data[85] = 450;
      set_data(110, 130, 100);
      run_case(1);
      check_eq("step.valid21",  o_valid[21], 0);
      check_eq("step.valid22",  o_valid[22], 1);
      check_eq("step.amp",      o_amp[22],   500);
      check_eq("step.time",     o_time[22],  5);
      check_eq("step.sat",      o_sat[22],   0);
      check_eq("step.fr22",     o_fr[22],    0);
      check_eq("step.fr39",     o_fr[39],    0);
      check_eq("step.fr40",     o_fr[40],    1);
      check_eq("glitch.cnt",    o_glit[55],  1);
      check_eq("glitch.fr",     o_fr[55],    1);
      check_eq("glitch.busy",   o_busy[55],  0);
      check_eq("clip.amp",      o_amp[87],   32767);
      check_eq("clip.sat",      o_sat[87],   1);
      check_eq("clip.time",     o_time[87],  70);
      check_eq("eq.busy",       o_busy[125], 0);
      check_eq("eq.valid",      o_valid[135], 0);

      // back-pressure drop, single-cycle accept, disable in PEAK, re-arm
      clear_stim(132, 100, 1'b1, 1'b0);
      for (int i = 94; i < 120; i++) s_en[i] = 1'b0;
      s_rdy[70] = 1'b1;
      set_data(5, 20, 300);
      set_data(45, 60, 700);
      set_data(80, 110, 300);
      set_data(125, 131, 300);
      run_case(2);
      check_eq("bp.amp69",    o_amp[69],   300);
      check_eq("bp.time69",   o_time[69],  5);
      check_eq("bp.valid69",  o_valid[69], 1);
      check_eq("bp.drop62",   o_drop[62],  1);
      check_eq("bp.valid70",  o_valid[70], 0);
      check_eq("dis.fr111",   o_fr[111],   0);
      check_eq("dis.fr112",   o_fr[112],   0);
      check_eq("dis.busy112", o_busy[112], 0);
      check_eq("dis.drop",    o_drop[131], 1);
      check_eq("dis.valid",   o_valid[131], 0);
      check_eq("rise.busy",   o_busy[131], 1);

      // asynchronous reset while in RISE, between clock edges
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("arst");

      for (int r = 0; r < 6; r++) begin
         gen_random(prof_len[r], prof_rdy[r], prof_dur[r]);
         run_case(3 + r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
